heart_hit_detector: RTL and testbench
=====================================

Name: heart_hit_detector

Overview:
- Consumer side of the bullet sprite interface: watches per-pixel bullet and heart sprite-on flags during the scan and detects overlap.
- At each frame end it applies damage to the player HP and runs invincibility frames and game-over.
- Sits between the sprite generators and the HUD/state controller.
- HP, hit and invincibility outputs feed the HP bar, heart blink logic and top-level game state machine.

Parameters:
- MAX_HP, 20, HP loaded on reset and in menu state (fits 7 bits).
- DAMAGE, 4, HP removed per hit frame.
- IFRAMES, 30, invincibility duration in frames after a hit (1..255).
- FRAME_END_X, 639, pixel x marking the frame-end event.
- FRAME_END_Y, 479, pixel y marking the frame-end event.

Ports:
- clk  in  1  pixel/system clock.
- rst_n  in  1  asynchronous active-low reset.
- state  in  2  game state: 0 menu, 1 fight, 2 dialogue, 3 reserved.
- x  in  10  current scan pixel x.
- y  in  10  current scan pixel y.
- bulletSpriteOn  in  1  bullet covers pixel (x,y) this cycle.
- heartSpriteOn  in  1  heart covers pixel (x,y) this cycle.
- hp  out  7  current player HP.
- hit  out  1  one-cycle pulse when damage is applied.
- invincible  out  1  high while invincibility frames remain.
- heartBlink  out  1  heart display mask: 0 hides the heart.
- gameOver  out  1  latched when HP reaches 0.

Behaviour:
- Reset (rst_n low, asynchronous): hp=MAX_HP, hit=0, invincible=0, heartBlink=1, gameOver=0, FSM=IDLE, overlap latch=0, frame counter=0.
- frame_end: registered decode, true for the single cycle with x==FRAME_END_X && y==FRAME_END_Y.
- Overlap latch:
  - Set on any cycle with state==1 && bulletSpriteOn && heartSpriteOn.
  - Cleared the cycle after frame_end.
  - A set coincident with frame_end counts toward the current frame.
- FSM states: IDLE, ACTIVE, INVULN, DEAD.
- IDLE:
  - state==1 -> ACTIVE.
  - state==0 additionally reloads hp=MAX_HP and clears gameOver.
- ACTIVE, at frame_end with overlap latched:
  - hp = hp - DAMAGE, saturating at 0 (no wrap).
  - hit=1 for exactly one cycle, the cycle after frame_end.
  - New hp==0 -> DEAD with gameOver=1.
  - Otherwise -> INVULN with counter=IFRAMES, invincible=1.
- INVULN:
  - Overlaps are ignored for damage.
  - Counter decrements at each frame_end.
  - At the frame_end where counter reaches 0 -> ACTIVE with invincible=0.
  - heartBlink = counter[2] (toggles every 4 frames).
  - heartBlink=1 in all other states.
- DEAD:
  - Holds hp=0 and gameOver=1.
  - Ignores overlaps.
  - Leaves only when state==0 -> IDLE with hp reload.
- state!=1 in ACTIVE/INVULN:
  - -> IDLE; counter clears, invincible=0; hp is retained unless state==0.
  - No damage is applied for a frame_end seen while state!=1.
- Simultaneous events: a state change to 0 in the same cycle as a damaging frame_end wins; hp reloads and no hit is issued.
- Reset mid-frame: the latch is discarded and the next frame starts clean.
- Latency: hp, hit, FSM and invincible update one clk after the frame_end cycle. The latch is combinationally sensitive to the sprite flags, registered.
- Arithmetic: the hp subtract uses a compare (hp<=DAMAGE -> 0).

Test Plan:
- Reset, then state=1, one overlap pixel mid-frame, then frame end -> hp 20->16, one-cycle hit, invincible=1, counter=30.
- Overlaps in each of the next 30 frames -> hp stays 16; heartBlink toggles every 4 frames; invincible drops after the 30th frame_end; the next overlapped frame gives hp=12.
- hp=3 with DAMAGE=4, overlap + frame_end -> hp=0 (no wrap), gameOver=1, DEAD; further overlaps give no hit.
- DEAD, then state=0 -> hp=20, gameOver=0, IDLE; state=1 -> ACTIVE.
- Overlap pixel asserted on the frame_end cycle itself -> damage applied at that frame; no overlap in a frame -> no hit.
- rst_n pulsed low mid-INVULN between clocks -> outputs return to reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/heart_hit_detector.sv
// Player heart damage tracker: latches bullet/heart overlap during the scan
// and applies damage, invincibility frames and game-over at each frame end.
module heart_hit_detector #(
    parameter int unsigned MAX_HP      = 20,
    parameter int unsigned DAMAGE      = 4,
    parameter int unsigned IFRAMES     = 30,
    parameter int unsigned FRAME_END_X = 639,
    parameter int unsigned FRAME_END_Y = 479
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] state,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       bulletSpriteOn,
    input  logic       heartSpriteOn,
    output logic [6:0] hp,
    output logic       hit,
    output logic       invincible,
    output logic       heartBlink,
    output logic       gameOver
);

    localparam logic [6:0] MAX_HP_L = 7'(MAX_HP);
    localparam logic [6:0] DMG_L    = 7'(DAMAGE);
    localparam logic [7:0] IFR_L    = 8'(IFRAMES);
    localparam logic [9:0] FEX_L    = 10'(FRAME_END_X);
    localparam logic [9:0] FEY_L    = 10'(FRAME_END_Y);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_INVULN,
        S_DEAD
    } fsm_t;

    fsm_t       fsm_q, fsm_d;
    logic [6:0] hp_q, hp_d;
    logic [7:0] cnt_q, cnt_d;
    logic       hit_q, hit_d;
    logic       go_q, go_d;
    logic       ovl_q, ovl_d;
    logic       fe_q, fe_d;

    logic fight, menu, ovl_set, ovl_now;

    always_comb begin
        fight   = (state == 2'd1);
        menu    = (state == 2'd0);
        fe_d    = (x == FEX_L) && (y == FEY_L);
        ovl_set = fight && bulletSpriteOn && heartSpriteOn;
        // A hit on the frame-end cycle itself still belongs to this frame
        ovl_now = ovl_q | ovl_set;
        ovl_d   = fe_q ? 1'b0 : ovl_now;
    end

    always_comb begin
        fsm_d = fsm_q;
        hp_d  = hp_q;
        cnt_d = cnt_q;
        hit_d = 1'b0;
        go_d  = go_q;
        unique case (fsm_q)
            S_IDLE: begin
                if (menu) begin
                    hp_d = MAX_HP_L;
                    go_d = 1'b0;
                end
                if (fight) fsm_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (!fight) begin
                    fsm_d = S_IDLE;
                    cnt_d = '0;
                    if (menu) begin
                        hp_d = MAX_HP_L;
                        go_d = 1'b0;
                    end
                end else if (fe_q && ovl_now) begin
                    hit_d = 1'b1;
                    if (hp_q <= DMG_L) begin
                        hp_d  = '0;
                        go_d  = 1'b1;
                        fsm_d = S_DEAD;
                    end else begin
                        hp_d  = hp_q - DMG_L;
                        cnt_d = IFR_L;
                        fsm_d = S_INVULN;
                    end
                end
            end
            S_INVULN: begin
                if (!fight) begin
                    fsm_d = S_IDLE;
                    cnt_d = '0;
                    if (menu) begin
                        hp_d = MAX_HP_L;
                        go_d = 1'b0;
                    end
                end else if (fe_q) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) fsm_d = S_ACTIVE;
                end
            end
            S_DEAD: begin
                hp_d = '0;
                go_d = 1'b1;
                if (menu) begin
                    hp_d  = MAX_HP_L;
                    go_d  = 1'b0;
                    fsm_d = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= S_IDLE;
            hp_q  <= MAX_HP_L;
            cnt_q <= '0;
            hit_q <= 1'b0;
            go_q  <= 1'b0;
            ovl_q <= 1'b0;
            fe_q  <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            hp_q  <= hp_d;
            cnt_q <= cnt_d;
            hit_q <= hit_d;
            go_q  <= go_d;
            ovl_q <= ovl_d;
            fe_q  <= fe_d;
        end
    end

    assign hp         = hp_q;
    assign hit        = hit_q;
    assign gameOver   = go_q;
    assign invincible = (fsm_q == S_INVULN);
    // Blink phase comes from the remaining i-frame count
    assign heartBlink = (fsm_q == S_INVULN) ? cnt_q[2] : 1'b1;

endmodule

// File: tb/tb_heart_hit_detector.sv
// Frame-level bench for heart_hit_detector: table of per-frame stimulus
// with expected outputs, routed through a scoreboard queue.
module tb_heart_hit_detector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] state;
    logic [9:0] x, y;
    logic       bulletSpriteOn, heartSpriteOn;
    logic [6:0] hp;
    logic       hit, invincible, heartBlink, gameOver;

    heart_hit_detector dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .state         (state),
        .x             (x),
        .y             (y),
        .bulletSpriteOn(bulletSpriteOn),
        .heartSpriteOn (heartSpriteOn),
        .hp            (hp),
        .hit           (hit),
        .invincible    (invincible),
        .heartBlink    (heartBlink),
        .gameOver      (gameOver)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic [1:0] st_end;
        bit         ovl;
        bit         at_end;
        int         hp;
        int         hits;
        bit         inv;
        bit         blink;
        bit         go;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   hit_cnt;

    function automatic void check(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic void add(logic [1:0] st, logic [1:0] st_end,
                                bit ovl, bit at_end, int ehp, int ehits,
                                bit inv, bit blink, bit go);
        vec_t v;
        v.st = st; v.st_end = st_end; v.ovl = ovl; v.at_end = at_end;
        v.hp = ehp; v.hits = ehits; v.inv = inv; v.blink = blink; v.go = go;
        tbl.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (hit) hit_cnt++;
    endtask

    task automatic run_frame(vec_t v, string tag);
        vec_t e;
        sb.push_back(v);
        hit_cnt = 0;
        x = 10'd100; y = 10'd100; state = v.st;
        bulletSpriteOn = v.ovl && !v.at_end;
        heartSpriteOn  = v.ovl && !v.at_end;
        step();
        bulletSpriteOn = 1'b0; heartSpriteOn = 1'b0; x = 10'd200;
        step();
        x = 10'd639; y = 10'd479; state = v.st_end;
        bulletSpriteOn = v.ovl && v.at_end;
        heartSpriteOn  = v.ovl && v.at_end;
        step();
        x = 10'd0; y = 10'd0;
        bulletSpriteOn = 1'b0; heartSpriteOn = 1'b0;
        for (int i = 0; i < 3; i++) step();
        e = sb.pop_front();
        check({tag, " hp"}, int'(hp), e.hp);
        check({tag, " hits"}, hit_cnt, e.hits);
        check({tag, " inv"}, int'(invincible), int'(e.inv));
        check({tag, " blink"}, int'(heartBlink), int'(e.blink));
        check({tag, " go"}, int'(gameOver), int'(e.go));
    endtask

    initial begin
        int h;
        vec_t v;
        // Playthrough: idle frame, then hits down to zero with full i-frames
        add(1, 1, 0, 0, 20, 0, 0, 1, 0);
        h = 20;
        while (h > 0) begin
            h = h - 4;
            add(1, 1, 1, 0, h, 1, h > 0, 1, h == 0);
            if (h > 0)
                for (int k = 1; k <= 30; k++)
                    add(1, 1, 1, 0, h, 0, k < 30,
                        (k < 30) ? (((30 - k) >> 2) & 1) : 1, 0);
        end
        add(1, 1, 1, 0, 0, 0, 0, 1, 1);
        add(1, 1, 1, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 20, 0, 0, 1, 0);
        add(1, 1, 0, 0, 20, 0, 0, 1, 0);
        add(1, 1, 1, 0, 16, 1, 1, 1, 0);
        add(2, 2, 1, 0, 16, 0, 0, 1, 0);
        add(1, 1, 0, 0, 16, 0, 0, 1, 0);
        add(1, 1, 1, 1, 12, 1, 1, 1, 0);
        add(2, 2, 0, 0, 12, 0, 0, 1, 0);
        add(1, 1, 0, 0, 12, 0, 0, 1, 0);
        add(1, 0, 1, 0, 20, 0, 0, 1, 0);
        add(1, 1, 0, 0, 20, 0, 0, 1, 0);

        rst_n = 1'b0; state = 2'd0; x = '0; y = '0;
        bulletSpriteOn = 1'b0; heartSpriteOn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset hp", int'(hp), 20);
        check("reset hit", int'(hit), 0);
        check("reset inv", int'(invincible), 0);
        check("reset blink", int'(heartBlink), 1);
        check("reset go", int'(gameOver), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++)
            run_frame(tbl[i], $sformatf("row%0d", i));

        // Hit once more, then pulse reset between edges while invulnerable
        v = tbl[0];
        v.ovl = 1; v.hp = 16; v.hits = 1; v.inv = 1;
        run_frame(v, "pre_rst");
        x = 10'd50; y = 10'd50; state = 2'd1;
        bulletSpriteOn = 1'b1; heartSpriteOn = 1'b1;
        step();
        bulletSpriteOn = 1'b0; heartSpriteOn = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async hp", int'(hp), 20);
        check("async inv", int'(invincible), 0);
        check("async blink", int'(heartBlink), 1);
        check("async go", int'(gameOver), 0);
        check("async hit", int'(hit), 0);
        @(negedge clk);
        rst_n = 1'b1;
        v = tbl[0];
        run_frame(v, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected done");
        $fatal(1);
    end

endmodule
